// File: rtl/byte_mem_pkg.sv
// Shared types and helpers for the byte-addressable data memory unit.
package byte_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPLIT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic [3:0] size_bytes(input size_e size);
    case (size)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      SZ_D:    return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/byte_mem_unit_ram.sv
// Word-organised storage with per-byte write enables and a registered read port.
module byte_lane_ram #(
  parameter int DATA_W = 64,
  parameter int WORDS  = 32
) (
  input  logic                       clock,
  input  logic [$clog2(WORDS)-1:0]   addr,
  input  logic [DATA_W/8-1:0]        we,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  // Byte-enabled write and read-before-write registered read.
  always_ff @(posedge clock) begin
    for (int b = 0; b < DATA_W/8; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/byte_mem_unit.sv
// Byte-addressable little-endian data memory; word-crossing accesses are split
// into two word beats by a small FSM.
module byte_mem_unit
  import byte_mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] d_in,
  output logic              resp_valid,
  output logic              resp_error,
  output logic [DATA_W-1:0] d_out
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int BA_W  = $clog2(DEPTH);
  localparam int WORDS = DEPTH / NB;
  localparam int WA_W  = BA_W - OFF_W;

  state_e              state_r;
  size_e               size_r;
  logic                write_r, signed_r, err_r, split_r;
  logic [OFF_W-1:0]    off_r;
  logic [WA_W-1:0]     word_hi_r;
  logic [DATA_W-1:0]   wdata_hi_r, hold_r;
  logic [NB-1:0]       wmask_hi_r;

  logic [3:0]          nbytes_s;
  logic [OFF_W-1:0]    off_s;
  logic [WA_W-1:0]     word_s;
  logic [ADDR_W:0]     end_s;
  logic                err_s, split_s, accept_s;
  logic [2*NB-1:0]     mask2_s;
  logic [DATA_W-1:0]   dmask_s;
  logic [2*DATA_W-1:0] data2_s;

  logic [WA_W-1:0]     ram_addr_s;
  logic [NB-1:0]       ram_we_s;
  logic [DATA_W-1:0]   ram_wdata_s, ram_rdata_s;

  logic [2*DATA_W-1:0] wide_s, shifted_s;
  logic [DATA_W-1:0]   ext_s;
  logic                sign_s;
  int                  nbits_s;

  assign req_ready  = (state_r == ST_IDLE) && !reset;
  assign accept_s   = req_valid && req_ready;
  assign resp_valid = (state_r == ST_RESP);
  assign resp_error = (state_r == ST_RESP) && err_r;
  assign d_out      = ((state_r == ST_RESP) && !err_r && !write_r) ? ext_s : '0;

  // Request decode: legality, lane mask and lane-aligned store data over two words.
  always_comb begin
    nbytes_s = size_bytes(size_e'(req_size));
    off_s    = address[OFF_W-1:0];
    word_s   = address[BA_W-1:OFF_W];
    // The +1 bit keeps the end-address check free of overflow for huge addresses.
    end_s    = {1'b0, address} + {{(ADDR_W-3){1'b0}}, nbytes_s};
    err_s    = ({1'b0, nbytes_s} > 5'(NB)) || (end_s > (ADDR_W+1)'(DEPTH));
    mask2_s  = '0;
    for (int b = 0; b < 2*NB; b++) begin
      mask2_s[b] = (b >= int'(off_s)) && (b < int'(off_s) + int'(nbytes_s));
    end
    dmask_s = '0;
    for (int i = 0; i < DATA_W; i++) begin
      dmask_s[i] = (i < 8*int'(nbytes_s)) ? d_in[i] : 1'b0;
    end
    data2_s = {{DATA_W{1'b0}}, dmask_s} << {off_s, 3'b000};
    split_s = |mask2_s[2*NB-1:NB];
  end

  // RAM port: first beat from the live request, second beat from captured fields.
  always_comb begin
    ram_addr_s  = word_s;
    ram_we_s    = '0;
    ram_wdata_s = data2_s[DATA_W-1:0];
    if (reset) begin
      ram_we_s = '0;
    end else if (state_r == ST_SPLIT) begin
      ram_addr_s  = word_hi_r;
      ram_we_s    = write_r ? wmask_hi_r : '0;
      ram_wdata_s = wdata_hi_r;
    end else if (accept_s && !err_s && req_write) begin
      ram_we_s = mask2_s[NB-1:0];
    end else begin
      ram_we_s = '0;
    end
  end

  byte_lane_ram #(.DATA_W(DATA_W), .WORDS(WORDS)) u_ram (
    .clock (clock),
    .addr  (ram_addr_s),
    .we    (ram_we_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Load assembly: realign the one or two words, then zero/sign extend.
  always_comb begin
    wide_s    = split_r ? {ram_rdata_s, hold_r} : {{DATA_W{1'b0}}, ram_rdata_s};
    shifted_s = wide_s >> {off_r, 3'b000};
    nbits_s   = 8 * int'(size_bytes(size_r));
    sign_s    = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == nbits_s - 1) begin
        sign_s = shifted_s[i];
      end else begin
        sign_s = sign_s;
      end
    end
    ext_s = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ext_s[i] = (i < nbits_s) ? shifted_s[i] : (signed_r & sign_s);
    end
  end

  // Control FSM and request capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      size_r     <= SZ_B;
      write_r    <= 1'b0;
      signed_r   <= 1'b0;
      err_r      <= 1'b0;
      split_r    <= 1'b0;
      off_r      <= '0;
      word_hi_r  <= '0;
      wdata_hi_r <= '0;
      wmask_hi_r <= '0;
      hold_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            size_r     <= size_e'(req_size);
            write_r    <= req_write;
            signed_r   <= req_signed;
            err_r      <= err_s;
            split_r    <= split_s && !err_s;
            off_r      <= off_s;
            word_hi_r  <= word_s + {{(WA_W-1){1'b0}}, 1'b1};
            wdata_hi_r <= data2_s[2*DATA_W-1:DATA_W];
            wmask_hi_r <= mask2_s[2*NB-1:NB];
            state_r    <= (split_s && !err_s) ? ST_SPLIT : ST_RESP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SPLIT: begin
          hold_r  <= ram_rdata_s;
          state_r <= ST_RESP;
        end
        ST_RESP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_mem_unit.sv
// Randomized scoreboard bench for byte_mem_unit against a byte-array reference model.
module tb_byte_mem_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [63:0] address = 64'd0;
  logic [63:0] d_in = 64'd0;
  logic        resp_valid, resp_error;
  logic [63:0] d_out;

  typedef struct {
    logic        err;
    logic [63:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem [256];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_acc = 0;
  bit          mon_on = 1'b0;

  byte_mem_unit #(.DATA_W(64), .DEPTH(256), .ADDR_W(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .address    (address),
    .d_in       (d_in),
    .resp_valid (resp_valid),
    .resp_error (resp_error),
    .d_out      (d_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clock) begin
    if (mon_on) begin
      if (resp_valid === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp: err=%0b data=%h at cycle %0d", resp_error, d_out, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (resp_error !== e.err || d_out !== e.data || cyc != e.cyc) begin
            fails++;
            $display("FAIL %s: got err=%0b data=%h cyc=%0d expected err=%0b data=%h cyc=%0d",
                     e.name, resp_error, d_out, cyc, e.err, e.data, e.cyc);
          end
        end
      end else begin
        tests++;
        if (resp_valid !== 1'b0 || resp_error !== 1'b0 || d_out !== 64'd0) begin
          fails++;
          $display("FAIL idle_outputs: got valid=%b err=%b data=%h expected 0/0/0",
                   resp_valid, resp_error, d_out);
        end
      end
    end
  end

  // Issue one request; the reference model updates/predicts at acceptance.
  // abort=1 models a split store cut short by reset after its first beat.
  task automatic issue(input bit wr, input int sz, input bit sg, input logic [63:0] addr,
                       input logic [63:0] data, input string name, input bit abort = 1'b0);
    int          n;
    bit          err, split;
    int          k, acc;
    logic [63:0] val;
    n     = 1 << sz;
    err   = (n > 8) || (addr > 64'(256 - n));
    split = !err && ((int'(addr[2:0]) + n) > 8);
    req_write  = wr;
    req_size   = 2'(sz);
    req_signed = sg;
    address    = addr;
    d_in       = data;
    req_valid  = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (req_ready === 1'b1) break;
    end
    if (k == 20) begin
      tests++;
      fails++;
      $display("FAIL %s accept_timeout: req_ready stayed %b, expected 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    val = 64'd0;
    if (!err && !wr) begin
      for (int j = 0; j < n; j++) val[8*j +: 8] = mem[8'(addr + 64'(j))];
      if (sg && n < 8 && val[8*n-1]) begin
        for (int i = 8*n; i < 64; i++) val[i] = 1'b1;
      end
    end
    if (!err && wr) begin
      for (int j = 0; j < n; j++) begin
        if (!abort || ((addr + 64'(j)) >> 3) == (addr >> 3)) mem[8'(addr + 64'(j))] = data[8*j +: 8];
      end
    end
    if (!abort) sb.push_back('{err, val, acc + (split ? 1 : 0), name});
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    last_acc  = acc;
    check({name, "_ready_low"}, {63'd0, req_ready}, 64'd0);
  endtask

  initial begin
    int prev;
    logic [63:0] a;
    int r;
    repeat (3) @(posedge clock);
    #1;
    check("reset_valid", {63'd0, resp_valid}, 64'd0);
    check("reset_dout", d_out, 64'd0);
    check("reset_ready_low", {63'd0, req_ready}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("ready_after_reset", {63'd0, req_ready}, 64'd1);
    mon_on = 1'b1;

    for (int w = 0; w < 32; w++) issue(1'b1, 3, 1'b0, 64'(w * 8), {$urandom, $urandom}, "init");

    issue(1'b1, 3, 1'b0, 64'd0, 64'h0123456789ABCDEF, "t1_st8");
    issue(1'b0, 3, 1'b0, 64'd0, 64'd0, "t1_ld8");
    issue(1'b1, 0, 1'b0, 64'd3, 64'h00000000000000AB, "t2_st1");
    issue(1'b0, 0, 1'b1, 64'd3, 64'd0, "t2_ld1s");
    issue(1'b0, 0, 1'b0, 64'd3, 64'd0, "t2_ld1u");
    issue(1'b0, 3, 1'b0, 64'd0, 64'd0, "t2_ld8");
    issue(1'b1, 3, 1'b0, 64'd5, 64'h1122334455667788, "t3_st8_split");
    issue(1'b0, 3, 1'b0, 64'd5, 64'd0, "t3_ld8_split");
    issue(1'b0, 2, 1'b0, 64'd8, 64'd0, "t3_ld4");
    issue(1'b0, 3, 1'b0, 64'd252, 64'd0, "t4_ld8_oob");
    issue(1'b1, 1, 1'b0, 64'd255, 64'hBEEF, "t4_st2_oob");
    issue(1'b0, 0, 1'b0, 64'd255, 64'd0, "t4_ld1_255");

    // Reset while the split store sits in its second beat.
    issue(1'b1, 3, 1'b0, 64'd5, 64'hA5A5A5A5A5A5A5A5, "t5_st8_abort", 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("t5_no_resp", {63'd0, resp_valid}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("t5_ready_after_reset", {63'd0, req_ready}, 64'd1);
    issue(1'b0, 3, 1'b0, 64'd0, 64'd0, "t5_ld8_w0");
    issue(1'b0, 3, 1'b0, 64'd8, 64'd0, "t5_ld8_w1");

    issue(1'b0, 3, 1'b0, 64'd0, 64'd0, "t6_ld0");
    for (int i = 1; i < 4; i++) begin
      prev = last_acc;
      issue(1'b0, 3, 1'b0, 64'(i * 8), 64'd0, "t6_ld");
      check("t6_accept_gap", 64'(last_acc - prev), 64'd2);
    end

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8) a = 64'($urandom_range(0, 255));
      else if (r == 8) a = 64'($urandom_range(248, 263));
      else a = {$urandom, $urandom};
      issue(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), a,
            {$urandom, $urandom}, "rand");
      repeat ($urandom_range(0, 1)) @(posedge clock);
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clock);
    @(negedge clock);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
